// File: rtl/hit_resolver.sv
// hit_resolver: once-per-frame hit registration, stun timers, health tracking and round result.
// Optional HIT_STATS_EN adds per-player landed-hit counters (p1_hits_landed, p2_hits_landed).
module hit_resolver #(
  parameter int HEALTH_INIT      = 3,
  parameter int HW               = 3,
  parameter int BASIC_DMG        = 1,
  parameter int DIR_DMG          = 2,
  parameter int HITSTUN_FRAMES   = 16,
  parameter int BLOCKSTUN_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          round_start,
  input  logic [1:0]    p1_hit_flag,
  input  logic [1:0]    p2_hit_flag,
  input  logic          p1_blocking,
  input  logic          p2_blocking,
  output logic [1:0]    p1_stun,
  output logic [1:0]    p2_stun,
  output logic [HW-1:0] p1_health,
  output logic [HW-1:0] p2_health,
  output logic          round_over,
  output logic [1:0]    winner
`ifdef HIT_STATS_EN
  ,
  output logic [7:0]    p1_hits_landed,
  output logic [7:0]    p2_hits_landed
`endif
);
  typedef enum logic [1:0] {IDLE, FIGHT, KO} state_t;
  state_t state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0][HW-1:0] hp_nx, hp;
  logic [1:0][1:0] stun, flag;
  logic [1:0] blk;
  logic tick;
`ifdef HIT_STATS_EN
  logic [1:0] hit;
  logic [1:0][7:0] cnt_q;
`endif
  assign flag = {p2_hit_flag, p1_hit_flag};
  assign blk  = {p2_blocking, p1_blocking};
  assign tick = frame_tick && state_q == FIGHT;
  // index v is the victim: p1_hit_flag means P1 was hit
  for (genvar v = 0; v < 2; v++) begin : g_v
    logic [7:0] tmr_q, tmr_d;
    logic [HW-1:0] hp_q, hp_d, dmg;
    logic kind_q, kind_d, armed_q, armed_d, valid, blocked;
    assign valid   = ^flag[v];
    assign blocked = flag[v] == 2'b01 && blk[v];
    assign dmg     = flag[v] == 2'b10 ? HW'(DIR_DMG) : HW'(BASIC_DMG);
    always_comb begin
      tmr_d   = tmr_q;
      hp_d    = hp_q;
      kind_d  = kind_q;
      armed_d = armed_q;
      if (round_start) begin
        tmr_d   = '0;
        hp_d    = HW'(HEALTH_INIT);
        kind_d  = 1'b0;
        armed_d = 1'b1;
      end else if (tick) begin
        if (!valid) armed_d = 1'b1;
        if (tmr_q != '0) tmr_d = tmr_q - 8'd1;
        else if (valid && armed_q) begin
          armed_d = 1'b0;
          kind_d  = blocked;
          tmr_d   = blocked ? 8'(BLOCKSTUN_FRAMES) : 8'(HITSTUN_FRAMES);
          hp_d    = blocked ? hp_q : (hp_q > dmg ? hp_q - dmg : '0);
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmr_q   <= '0;
        hp_q    <= HW'(HEALTH_INIT);
        kind_q  <= 1'b0;
        armed_q <= 1'b1;
      end else begin
        tmr_q   <= tmr_d;
        hp_q    <= hp_d;
        kind_q  <= kind_d;
        armed_q <= armed_d;
      end
    end
    assign hp_nx[v] = hp_d;
    assign hp[v]    = hp_q;
    assign stun[v]  = (state_q == KO || tmr_q == '0) ? 2'b00 : (kind_q ? 2'b10 : 2'b01);
`ifdef HIT_STATS_EN
    assign hit[v] = !round_start && tick && tmr_q == '0 && valid && armed_q && !blocked;
`endif
  end
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    if (round_start) begin
      state_d = FIGHT;
      win_d   = 2'b00;
    end else if (tick && (hp_nx[0] == '0 || hp_nx[1] == '0)) begin
      state_d = KO;
      win_d   = {hp_nx[0] == '0, hp_nx[1] == '0};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end
  assign p1_stun    = stun[0];
  assign p2_stun    = stun[1];
  assign p1_health  = hp[0];
  assign p2_health  = hp[1];
  assign round_over = state_q == KO;
  assign winner     = win_q;
`ifdef HIT_STATS_EN
  // a player's count grows when the opponent takes an unblocked registered hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (round_start) cnt_q <= '0;
    else begin
      if (hit[1] && cnt_q[0] != 8'hff) cnt_q[0] <= cnt_q[0] + 8'd1;
      if (hit[0] && cnt_q[1] != 8'hff) cnt_q[1] <= cnt_q[1] + 8'd1;
    end
  end
  assign p1_hits_landed = cnt_q[0];
  assign p2_hits_landed = cnt_q[1];
`endif
endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: vector table, hand-written corner sequences and random stimulus against a frame-level model.
module tb_hit_resolver;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, round_start = 1'b0;
  logic [1:0] p1_hit_flag = 2'b00, p2_hit_flag = 2'b00;
  logic p1_blocking = 1'b0, p2_blocking = 1'b0;
  logic [1:0] p1_stun, p2_stun, winner;
  logic [2:0] p1_health, p2_health;
  logic round_over;
`ifdef HIT_STATS_EN
  logic [7:0] p1_hits_landed, p2_hits_landed;
`endif

  hit_resolver dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .round_start(round_start),
    .p1_hit_flag(p1_hit_flag), .p2_hit_flag(p2_hit_flag),
    .p1_blocking(p1_blocking), .p2_blocking(p2_blocking),
    .p1_stun(p1_stun), .p2_stun(p2_stun), .p1_health(p1_health), .p2_health(p2_health),
    .round_over(round_over), .winner(winner)
`ifdef HIT_STATS_EN
    , .p1_hits_landed(p1_hits_landed), .p2_hits_landed(p2_hits_landed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  // frame-level model: 0 idle, 1 fight, 2 KO
  int m_st, m_win, m_hp[2], m_tm[2], m_kb[2], m_arm[2], m_cnt[2];

  typedef struct {
    bit rs; bit ft; bit [1:0] f1; bit [1:0] f2; bit b1; bit b2;
    int h1; int h2; int s1; int s2; int ro; int w;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int pack(int h1, int h2, int s1, int s2, int ro, int w);
    return (h1 << 10) | (h2 << 7) | (s1 << 5) | (s2 << 3) | (ro << 2) | w;
  endfunction

  function automatic int m_stun(int v);
    return (m_st == 2 || m_tm[v] == 0) ? 0 : (m_kb[v] != 0 ? 2 : 1);
  endfunction

  task automatic model_round();
    for (int v = 0; v < 2; v++) begin
      m_hp[v] = 3; m_tm[v] = 0; m_kb[v] = 0; m_arm[v] = 1; m_cnt[v] = 0;
    end
    m_win = 0;
  endtask

  task automatic model_reset();
    model_round();
    m_st = 0;
  endtask

  task automatic model_step(input bit rs, input bit ft, input bit [1:0] f1, input bit [1:0] f2,
                            input bit b1, input bit b2);
    int f[2], b[2];
    bit valid;
    f[0] = f1; f[1] = f2; b[0] = b1; b[1] = b2;
    if (rs) begin
      model_round();
      m_st = 1;
    end else if (ft && m_st == 1) begin
      for (int v = 0; v < 2; v++) begin
        valid = f[v] == 1 || f[v] == 2;
        if (!valid) m_arm[v] = 1;
        if (m_tm[v] > 0) m_tm[v]--;
        else if (valid && m_arm[v] == 1) begin
          m_arm[v] = 0;
          if (f[v] == 1 && b[v] == 1) begin
            m_kb[v] = 1; m_tm[v] = 8;
          end else begin
            m_kb[v] = 0; m_tm[v] = 16;
            m_hp[v] = m_hp[v] - (f[v] == 2 ? 2 : 1);
            if (m_hp[v] < 0) m_hp[v] = 0;
            if (m_cnt[1-v] < 255) m_cnt[1-v]++;
          end
        end
      end
      if (m_hp[0] == 0 || m_hp[1] == 0) begin
        m_st = 2;
        m_win = (m_hp[0] == 0 ? 2 : 0) | (m_hp[1] == 0 ? 1 : 0);
      end
    end
  endtask

  task automatic compare_model();
    chk("model_outputs", pack(p1_health, p2_health, p1_stun, p2_stun, round_over, winner),
        pack(m_hp[0], m_hp[1], m_stun(0), m_stun(1), m_st == 2, m_win));
`ifdef HIT_STATS_EN
    chk("model_hits", {p1_hits_landed, p2_hits_landed}, (m_cnt[0] << 8) | m_cnt[1]);
`endif
  endtask

  task automatic step(input bit rs, input bit ft, input bit [1:0] f1, input bit [1:0] f2,
                      input bit b1, input bit b2);
    @(negedge clk);
    round_start = rs; frame_tick = ft;
    p1_hit_flag = f1; p2_hit_flag = f2;
    p1_blocking = b1; p2_blocking = b2;
    @(posedge clk);
    model_step(rs, ft, f1, f2, b1, b2);
    #1 compare_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1, 2'b00, 2'b00, 0, 0);
  endtask

  function automatic int now_packed();
    return pack(p1_health, p2_health, p1_stun, p2_stun, round_over, winner);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{0, 1, 2'b00, 2'b01, 0, 0, 3, 3, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 2'b00, 2'b00, 0, 0, 3, 3, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 2'b00, 2'b01, 0, 0, 3, 2, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 2'b00, 2'b01, 0, 0, 3, 2, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 2'b00, 2'b00, 0, 0, 3, 2, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 2'b00, 2'b10, 0, 0, 3, 2, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 2'b01, 2'b00, 1, 0, 3, 2, 2, 1, 0, 0};
    tbl[7]  = '{1, 1, 2'b10, 2'b00, 0, 0, 3, 3, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 2'b10, 2'b00, 1, 0, 1, 3, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 2'b00, 2'b11, 0, 0, 1, 3, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 2'b00, 2'b00, 0, 0, 3, 3, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 2'b00, 2'b10, 0, 1, 3, 1, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 2'b00, 2'b00, 0, 0, 3, 3, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 2'b10, 2'b10, 0, 0, 1, 1, 1, 1, 0, 0};
    tbl[14] = '{0, 1, 2'b00, 2'b00, 0, 0, 1, 1, 1, 1, 0, 0};
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", now_packed(), pack(3, 3, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rs, tbl[i].ft, tbl[i].f1, tbl[i].f2, tbl[i].b1, tbl[i].b2);
      chk($sformatf("vec%0d", i), now_packed(),
          pack(tbl[i].h1, tbl[i].h2, tbl[i].s1, tbl[i].s2, tbl[i].ro, tbl[i].w));
    end

    // trade to a double KO, then KO ignores flags, round_start restarts
    idle(14);
    chk("trade_stun_last", now_packed(), pack(1, 1, 1, 1, 0, 0));
    idle(1);
    chk("trade_stun_end", now_packed(), pack(1, 1, 0, 0, 0, 0));
    step(0, 1, 2'b01, 2'b01, 0, 0);
    chk("double_ko", now_packed(), pack(0, 0, 0, 0, 1, 3));
    step(0, 1, 2'b10, 2'b00, 0, 0);
    chk("ko_ignores_flags", now_packed(), pack(0, 0, 0, 0, 1, 3));
    step(1, 0, 2'b00, 2'b00, 0, 0);
    chk("restart_after_ko", now_packed(), pack(3, 3, 0, 0, 0, 0));

    // hitstun length
    step(0, 1, 2'b00, 2'b01, 0, 0);
    n = 0;
    while (p2_stun == 2'b01 && n < 40) begin
      n++;
      idle(1);
    end
    chk("hitstun_frames", n, 16);
    chk("basic_damage", p2_health, 2);

    // held flag registers once, even past the stun window
    step(1, 0, 2'b00, 2'b00, 0, 0);
    repeat (20) step(0, 1, 2'b00, 2'b01, 0, 0);
    chk("held_flag_once", now_packed(), pack(3, 2, 0, 0, 0, 0));
    step(0, 1, 2'b00, 2'b00, 0, 0);
    step(0, 1, 2'b00, 2'b01, 0, 0);
    chk("rearm_after_release", now_packed(), pack(3, 1, 0, 1, 0, 0));

    // held directional for 5 ticks, then a saturating KO hit
    step(1, 0, 2'b00, 2'b00, 0, 0);
    repeat (5) step(0, 1, 2'b00, 2'b10, 0, 0);
    chk("held_dir_once", p2_health, 1);
    idle(12);
    step(0, 1, 2'b00, 2'b10, 0, 0);
    chk("p1_wins_saturate", now_packed(), pack(3, 0, 0, 0, 1, 1));

    // round_start with tick in mid-hitstun
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(0, 1, 2'b01, 2'b00, 0, 0);
    idle(11);
    chk("mid_hitstun", now_packed(), pack(2, 3, 1, 0, 0, 0));
    step(1, 1, 2'b10, 2'b00, 0, 0);
    chk("restart_overrides_tick", now_packed(), pack(3, 3, 0, 0, 0, 0));
    step(0, 1, 2'b01, 2'b00, 0, 0);
    chk("hit_after_restart", now_packed(), pack(2, 3, 1, 0, 0, 0));

    // three P1 attacks, middle one blocked
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(0, 1, 2'b00, 2'b01, 0, 0);
    idle(16);
    step(0, 1, 2'b00, 2'b01, 0, 1);
    chk("blocked_no_damage", now_packed(), pack(3, 2, 0, 2, 0, 0));
    idle(8);
    step(0, 1, 2'b00, 2'b01, 0, 0);
    chk("third_hit", p2_health, 1);
`ifdef HIT_STATS_EN
    chk("hits_landed", p1_hits_landed, 2);
`endif

    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1 chk("async_reset", now_packed(), pack(3, 3, 0, 0, 0, 0));
`ifdef HIT_STATS_EN
    chk("async_reset_hits", {p1_hits_landed, p2_hits_landed}, 0);
`endif
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 2'b01, 2'b01, 0, 0);
    chk("idle_ignores_flags", now_packed(), pack(3, 3, 0, 0, 0, 0));

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
